// File: rtl/sp_axi_pkg.sv
// rtl/sp_axi_pkg.sv - shared AXI W-channel beat types and strobe-width helper
package sp_axi_pkg;

  localparam int AXI_WDATA_WIDTH_DEFAULT = 32;

  function automatic int strb_width(input int data_width);
    return data_width / 8;
  endfunction

  // One beat type per legal data width; the buffer picks the one matching its parameter.
  typedef struct packed {
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } wbeat32_t;

  typedef struct packed {
    logic [63:0] wdata;
    logic [7:0]  wstrb;
  } wbeat64_t;

endpackage

// File: rtl/axi_lite_wbuf_ram.sv
// rtl/axi_lite_wbuf_ram.sv - beat storage array, one write port, async read port
module axi_lite_wbuf_ram
  import sp_axi_pkg::*;
#(
  parameter int  DEPTH  = 4,
  parameter int  AW     = 2,
  parameter type beat_t = wbeat32_t
) (
  input  logic          aclk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  beat_t         wbeat,
  input  logic [AW-1:0] raddr,
  output beat_t         rbeat
);

  beat_t mem [DEPTH];

  always_ff @(posedge aclk) begin
    if (we) mem[waddr] <= wbeat;
  end

  assign rbeat = mem[raddr];

endmodule

// File: rtl/axi_lite_wbuf.sv
// rtl/axi_lite_wbuf.sv - AXI W-channel FIFO buffer; AXI_LITE_WBUF_STRB_MASK_EN zeroes unstrobed bytes at write
module axi_lite_wbuf
  import sp_axi_pkg::*;
#(
  parameter int AXI_WDATA_WIDTH = 32,
  parameter int DEPTH           = 4
) (
  input  logic                                   aclk,
  input  logic                                   aresetn,
  input  logic                                   flush,
  input  logic                                   s_wvalid,
  output logic                                   s_wready,
  input  logic [AXI_WDATA_WIDTH-1:0]             s_wdata,
  input  logic [strb_width(AXI_WDATA_WIDTH)-1:0] s_wstrb,
  output logic                                   m_wvalid,
  input  logic                                   m_wready,
  output logic [AXI_WDATA_WIDTH-1:0]             m_wdata,
  output logic [strb_width(AXI_WDATA_WIDTH)-1:0] m_wstrb,
  output logic [$clog2(DEPTH+1)-1:0]             level
);

  localparam int SW = strb_width(AXI_WDATA_WIDTH);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [AW-1:0]              wr_ptr, rd_ptr;
  logic                       ready_en;
  logic                       push, pop;
  logic [AXI_WDATA_WIDTH-1:0] wdata_in;

  // ready_en keeps s_wready low until the first edge with aresetn sampled high
  assign s_wready = aresetn && ready_en && (level != LW'(DEPTH)) && !flush;
  assign m_wvalid = aresetn && (level != '0);
  assign push     = s_wvalid && s_wready;
  assign pop      = m_wvalid && m_wready && !flush;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   level <= level + 1'b1;
          2'b01:   level <= level - 1'b1;
          default: level <= level;
        endcase
      end
    end
  end

  always_comb begin
    wdata_in = s_wdata;
`ifdef AXI_LITE_WBUF_STRB_MASK_EN
    for (int i = 0; i < SW; i++) begin
      if (!s_wstrb[i]) wdata_in[8*i +: 8] = 8'h00;
    end
`else
`endif
  end

  if (AXI_WDATA_WIDTH == 64) begin : g_w64
    wbeat64_t wbeat, rbeat;
    assign wbeat.wdata = wdata_in;
    assign wbeat.wstrb = s_wstrb;
    axi_lite_wbuf_ram #(.DEPTH(DEPTH), .AW(AW), .beat_t(wbeat64_t)) u_ram (
      .aclk  (aclk),
      .we    (push),
      .waddr (wr_ptr),
      .wbeat (wbeat),
      .raddr (rd_ptr),
      .rbeat (rbeat)
    );
    assign m_wdata = rbeat.wdata;
    assign m_wstrb = rbeat.wstrb;
  end else begin : g_w32
    wbeat32_t wbeat, rbeat;
    assign wbeat.wdata = wdata_in;
    assign wbeat.wstrb = s_wstrb;
    axi_lite_wbuf_ram #(.DEPTH(DEPTH), .AW(AW), .beat_t(wbeat32_t)) u_ram (
      .aclk  (aclk),
      .we    (push),
      .waddr (wr_ptr),
      .wbeat (wbeat),
      .raddr (rd_ptr),
      .rbeat (rbeat)
    );
    assign m_wdata = rbeat.wdata;
    assign m_wstrb = rbeat.wstrb;
  end

endmodule

// File: tb/tb_axi_lite_wbuf.sv
// tb/tb_axi_lite_wbuf.sv - directed vector bench for axi_lite_wbuf
module tb_axi_lite_wbuf;

  logic        aclk = 1'b0;
  logic        aresetn, flush, s_wvalid, s_wready, m_wvalid, m_wready;
  logic [31:0] s_wdata, m_wdata;
  logic [3:0]  s_wstrb, m_wstrb;
  logic [2:0]  level;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 aclk = ~aclk;

  axi_lite_wbuf dut (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .flush    (flush),
    .s_wvalid (s_wvalid),
    .s_wready (s_wready),
    .s_wdata  (s_wdata),
    .s_wstrb  (s_wstrb),
    .m_wvalid (m_wvalid),
    .m_wready (m_wready),
    .m_wdata  (m_wdata),
    .m_wstrb  (m_wstrb),
    .level    (level)
  );

  typedef struct {
    logic        rstn, fl, sv;
    logic [31:0] sd;
    logic [3:0]  ss;
    logic        mr;
    logic        e_sr, e_mv;
    logic [31:0] e_d;
    logic [3:0]  e_s;
    logic [2:0]  e_lvl;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic rstn, logic fl, logic sv, logic [31:0] sd, logic [3:0] ss,
                              logic mr, logic e_sr, logic e_mv, logic [31:0] e_d,
                              logic [3:0] e_s, logic [2:0] e_lvl);
    vec_t v;
    v.rstn = rstn; v.fl = fl; v.sv = sv; v.sd = sd; v.ss = ss; v.mr = mr;
    v.e_sr = e_sr; v.e_mv = e_mv; v.e_d = e_d; v.e_s = e_s; v.e_lvl = e_lvl;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rstn, input logic fl, input logic sv, input logic [31:0] sd,
                       input logic [3:0] ss, input logic mr);
    @(negedge aclk);
    aresetn = rstn; flush = fl; s_wvalid = sv; s_wdata = sd; s_wstrb = ss; m_wready = mr;
    #1;
  endtask

  logic [31:0] mask_exp;

  initial begin
`ifdef AXI_LITE_WBUF_STRB_MASK_EN
    mask_exp = 32'h00BB00DD;
`else
    mask_exp = 32'hAABBCCDD;
`endif
    //         rstn fl sv data          strb  mr  sr mv exp_data      strb  lvl
    vq.push_back(mk(0, 0, 0, 32'h0,        4'hF, 0,  0, 0, 32'h0,        4'hF, 3'd0));
    vq.push_back(mk(1, 0, 0, 32'h0,        4'hF, 0,  0, 0, 32'h0,        4'hF, 3'd0));
    vq.push_back(mk(1, 0, 0, 32'h0,        4'hF, 0,  1, 0, 32'h0,        4'hF, 3'd0));
    vq.push_back(mk(1, 0, 1, 32'h11111111, 4'hF, 0,  1, 0, 32'h0,        4'hF, 3'd0));
    vq.push_back(mk(1, 0, 1, 32'h22222222, 4'hF, 0,  1, 1, 32'h11111111, 4'hF, 3'd1));
    vq.push_back(mk(1, 0, 1, 32'h33333333, 4'hF, 0,  1, 1, 32'h11111111, 4'hF, 3'd2));
    vq.push_back(mk(1, 0, 1, 32'h44444444, 4'hF, 0,  1, 1, 32'h11111111, 4'hF, 3'd3));
    vq.push_back(mk(1, 0, 1, 32'h55555555, 4'hF, 0,  0, 1, 32'h11111111, 4'hF, 3'd4));
    vq.push_back(mk(1, 0, 1, 32'h55555555, 4'hF, 1,  0, 1, 32'h11111111, 4'hF, 3'd4));
    vq.push_back(mk(1, 0, 1, 32'h55555555, 4'hF, 1,  1, 1, 32'h22222222, 4'hF, 3'd3));
    vq.push_back(mk(1, 0, 0, 32'h0,        4'hF, 1,  1, 1, 32'h33333333, 4'hF, 3'd3));
    vq.push_back(mk(1, 0, 0, 32'h0,        4'hF, 1,  1, 1, 32'h44444444, 4'hF, 3'd2));
    vq.push_back(mk(1, 0, 0, 32'h0,        4'hF, 1,  1, 1, 32'h55555555, 4'hF, 3'd1));
    vq.push_back(mk(1, 0, 0, 32'h0,        4'hF, 1,  1, 0, 32'h0,        4'hF, 3'd0));
    // flush with concurrent push and pop
    vq.push_back(mk(1, 0, 1, 32'hA1A1A1A1, 4'hF, 0,  1, 0, 32'h0,        4'hF, 3'd0));
    vq.push_back(mk(1, 0, 1, 32'hA2A2A2A2, 4'hF, 0,  1, 1, 32'hA1A1A1A1, 4'hF, 3'd1));
    vq.push_back(mk(1, 0, 1, 32'hA3A3A3A3, 4'hF, 0,  1, 1, 32'hA1A1A1A1, 4'hF, 3'd2));
    vq.push_back(mk(1, 1, 1, 32'hBADBAD00, 4'hF, 1,  0, 1, 32'hA1A1A1A1, 4'hF, 3'd3));
    vq.push_back(mk(1, 0, 0, 32'h0,        4'hF, 1,  1, 0, 32'h0,        4'hF, 3'd0));
    // reset mid-operation
    vq.push_back(mk(1, 0, 1, 32'hC1C1C1C1, 4'hF, 0,  1, 0, 32'h0,        4'hF, 3'd0));
    vq.push_back(mk(1, 0, 1, 32'hC2C2C2C2, 4'hF, 0,  1, 1, 32'hC1C1C1C1, 4'hF, 3'd1));
    vq.push_back(mk(0, 0, 0, 32'h0,        4'hF, 0,  0, 0, 32'h0,        4'hF, 3'd2));
    vq.push_back(mk(1, 0, 0, 32'h0,        4'hF, 0,  0, 0, 32'h0,        4'hF, 3'd0));
    vq.push_back(mk(1, 0, 1, 32'hDEADBEEF, 4'hF, 0,  1, 0, 32'h0,        4'hF, 3'd0));
    vq.push_back(mk(1, 0, 0, 32'h0,        4'hF, 1,  1, 1, 32'hDEADBEEF, 4'hF, 3'd1));
    vq.push_back(mk(1, 0, 0, 32'h0,        4'hF, 0,  1, 0, 32'h0,        4'hF, 3'd0));
    // strobe pass-through / masking
    vq.push_back(mk(1, 0, 1, 32'hAABBCCDD, 4'h5, 0,  1, 0, 32'h0,        4'hF, 3'd0));
    vq.push_back(mk(1, 0, 0, 32'h0,        4'hF, 1,  1, 1, mask_exp,     4'h5, 3'd1));
    vq.push_back(mk(1, 0, 0, 32'h0,        4'hF, 0,  1, 0, 32'h0,        4'hF, 3'd0));

    aresetn = 1'b0; flush = 1'b0; s_wvalid = 1'b0; s_wdata = '0; s_wstrb = 4'hF; m_wready = 1'b0;
    repeat (2) @(posedge aclk);

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].rstn, vq[i].fl, vq[i].sv, vq[i].sd, vq[i].ss, vq[i].mr);
      check($sformatf("v%0d s_wready", i), {31'b0, s_wready}, {31'b0, vq[i].e_sr});
      check($sformatf("v%0d m_wvalid", i), {31'b0, m_wvalid}, {31'b0, vq[i].e_mv});
      check($sformatf("v%0d level", i), {29'b0, level}, {29'b0, vq[i].e_lvl});
      if (vq[i].e_mv) begin
        check($sformatf("v%0d m_wdata", i), m_wdata, vq[i].e_d);
        check($sformatf("v%0d m_wstrb", i), {28'b0, m_wstrb}, {28'b0, vq[i].e_s});
      end
    end

    // streaming: 100 beats with push and pop every cycle
    for (int i = 0; i < 100; i++) begin
      drive(1, 0, 1, 32'h1000 + i, 4'hF, 1);
      check($sformatf("stream%0d s_wready", i), {31'b0, s_wready}, 32'd1);
      if (i == 0) begin
        check("stream0 level", {29'b0, level}, 32'd0);
        check("stream0 m_wvalid", {31'b0, m_wvalid}, 32'd0);
      end else begin
        check($sformatf("stream%0d level", i), {29'b0, level}, 32'd1);
        check($sformatf("stream%0d m_wvalid", i), {31'b0, m_wvalid}, 32'd1);
        check($sformatf("stream%0d m_wdata", i), m_wdata, 32'h1000 + i - 1);
      end
    end
    drive(1, 0, 0, 32'h0, 4'hF, 1);
    check("stream tail m_wvalid", {31'b0, m_wvalid}, 32'd1);
    check("stream tail m_wdata", m_wdata, 32'h1000 + 99);
    drive(1, 0, 0, 32'h0, 4'hF, 0);
    check("stream end level", {29'b0, level}, 32'd0);
    check("stream end m_wvalid", {31'b0, m_wvalid}, 32'd0);

    // pointer wrap: fill to full twice over with interleaved drains
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++) drive(1, 0, 1, 32'h2000 + 16*r + k, 4'hF, 0);
      drive(1, 0, 1, 32'hFFFFFFFF, 4'hF, 0);
      check($sformatf("wrap%0d full s_wready", r), {31'b0, s_wready}, 32'd0);
      check($sformatf("wrap%0d full level", r), {29'b0, level}, 32'd4);
      for (int k = 0; k < 4; k++) begin
        drive(1, 0, 0, 32'h0, 4'hF, 1);
        check($sformatf("wrap%0d drain%0d", r, k), m_wdata, 32'h2000 + 16*r + k);
      end
    end
    drive(1, 0, 0, 32'h0, 4'hF, 0);
    check("wrap empty level", {29'b0, level}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
